// File: rtl/board_pkg.sv
// Shared constants, tile type and turn FSM states for the board race.
// Imported by the turn controller, ui_render and the test top.
package board_pkg;

  localparam int TILE_SPACING   = 60;
  localparam int START_X        = 20;
  localparam int MAX_TILE       = 10;
  localparam int TIMEOUT_CYCLES = 25_000_000;

  typedef logic [3:0] tile_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    SWITCH,
    GAME_OVER
  } state_t;

  function automatic logic [9:0] tile_to_x(
    tile_t t,
    int    start_x,
    int    spacing
  );
    return 10'(start_x + int'(t) * spacing);
  endfunction

  // Overshoot past the flag lands exactly on the flag.
  function automatic tile_t step_tile(
    tile_t       t,
    logic [1:0]  steps,
    int          max_tile
  );
    logic [4:0] sum;
    sum = {1'b0, t} + {3'b000, steps};
    return (int'(sum) > max_tile) ? tile_t'(max_tile) : sum[3:0];
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Watchdog for the animation wait: flags expiry after TIMEOUT_CYCLES-1.
// Holds at the expired count until cleared.
module turn_timer #(
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count;

  assign expired = (count == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/board_turn_controller.sv
// Two-player turn sequencer: applies a move, waits for the animation
// (or a timeout), then hands over the turn or declares the winner.
module board_turn_controller #(
  parameter int TILE_SPACING   = 60,
  parameter int START_X        = 20,
  parameter int MAX_TILE       = 10,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_req,
  input  logic [1:0] move_steps,
  input  logic       turn_done,
  output logic [9:0] player1_pos_x,
  output logic [9:0] player2_pos_x,
  output logic       pos_valid,
  output logic       active_player,
  output logic       busy,
  output logic       game_over,
  output logic       winner,
  output logic [3:0] p1_tile,
  output logic [3:0] p2_tile
);

  import board_pkg::*;

  state_t     state;
  tile_t      p1_t;
  tile_t      p2_t;
  tile_t      mover_t;
  tile_t      next_t;
  logic [1:0] steps_q;
  logic       restart;
  logic       timer_clr;
  logic       timer_exp;
  logic       turn_end;

  assign p1_tile   = p1_t;
  assign p2_tile   = p2_t;
  assign restart   = rst || new_game;
  assign mover_t   = active_player ? p2_t : p1_t;
  assign next_t    = step_tile(mover_t, steps_q, MAX_TILE);
  assign timer_clr = restart || (state != WAIT_DONE);

  // The pos_valid cycle is the first WAIT_DONE cycle; ignore done there.
  assign turn_end  = (turn_done && !pos_valid) || timer_exp;

  turn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clr),
    .enable (state == WAIT_DONE),
    .expired(timer_exp)
  );

  always_ff @(posedge clk) begin
    if (restart) begin
      state         <= IDLE;
      steps_q       <= 2'd0;
      p1_t          <= '0;
      p2_t          <= '0;
      player1_pos_x <= tile_to_x('0, START_X, TILE_SPACING);
      player2_pos_x <= tile_to_x('0, START_X, TILE_SPACING);
      pos_valid     <= 1'b0;
      active_player <= 1'b0;
      busy          <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (move_req && move_steps != 2'd0) begin
            steps_q <= move_steps;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (active_player) begin
            p2_t          <= next_t;
            player2_pos_x <= tile_to_x(next_t, START_X, TILE_SPACING);
          end else begin
            p1_t          <= next_t;
            player1_pos_x <= tile_to_x(next_t, START_X, TILE_SPACING);
          end
          pos_valid <= 1'b1;
          state     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (turn_end) begin
            if (mover_t == tile_t'(MAX_TILE)) begin
              game_over <= 1'b1;
              winner    <= active_player;
              busy      <= 1'b0;
              state     <= GAME_OVER;
            end else begin
              state <= SWITCH;
            end
          end
        end
        SWITCH: begin
          active_player <= ~active_player;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        GAME_OVER: begin
          state <= GAME_OVER;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_turn_controller.sv
// Random turn sequences against a tile-level model of the race rules.
// Uses a 16-cycle timeout so the timeout path is exercised quickly.
module tb_board_turn_controller;

  logic       clk;
  logic       rst;
  logic       new_game;
  logic       move_req;
  logic [1:0] move_steps;
  logic       turn_done;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic       busy;
  logic       game_over;
  logic       winner;
  logic [3:0] p1_tile;
  logic [3:0] p2_tile;

  board_turn_controller #(
    .TILE_SPACING  (60),
    .START_X       (20),
    .MAX_TILE      (10),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .new_game     (new_game),
    .move_req     (move_req),
    .move_steps   (move_steps),
    .turn_done    (turn_done),
    .player1_pos_x(player1_pos_x),
    .player2_pos_x(player2_pos_x),
    .pos_valid    (pos_valid),
    .active_player(active_player),
    .busy         (busy),
    .game_over    (game_over),
    .winner       (winner),
    .p1_tile      (p1_tile),
    .p2_tile      (p2_tile)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int m_tile[2];
  int m_act;
  int m_go;
  int m_win;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_tile[0] = 0;
    m_tile[1] = 0;
    m_act     = 0;
    m_go      = 0;
    m_win     = 0;
  endtask

  task automatic check_state(input string tag, input int e_busy, input int e_pv);
    chk({tag, ".p1x"},  int'(player1_pos_x), 20 + 60 * m_tile[0]);
    chk({tag, ".p2x"},  int'(player2_pos_x), 20 + 60 * m_tile[1]);
    chk({tag, ".p1t"},  int'(p1_tile), m_tile[0]);
    chk({tag, ".p2t"},  int'(p2_tile), m_tile[1]);
    chk({tag, ".act"},  int'(active_player), m_act);
    chk({tag, ".busy"}, int'(busy), e_busy);
    chk({tag, ".pv"},   int'(pos_valid), e_pv);
    chk({tag, ".go"},   int'(game_over), m_go);
    chk({tag, ".win"},  int'(winner), m_win);
  endtask

  // steps=0 picks a random legal step count
  task automatic play_turn(
    input int steps,
    input bit use_done,
    input bit ghost,
    input bit drop,
    input bit do_rst
  );
    int s;
    int a;
    int w;
    s = (steps == 0) ? int'($urandom_range(1, 3)) : steps;
    a = m_act;
    move_req   = 1'b1;
    move_steps = 2'(s);
    tick();
    move_req = 1'b0;
    check_state("issue", 1, 0);
    m_tile[a] = (m_tile[a] + s > 10) ? 10 : m_tile[a] + s;
    tick();
    check_state("pv", 1, 1);
    turn_done = ghost;
    w = use_done ? int'($urandom_range(2, 10)) : 15;
    for (int i = 0; i < w; i++) begin
      if (do_rst && i == 1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check_state("rst_mid", 0, 0);
        return;
      end
      if (drop && i == 0) begin
        move_req   = 1'b1;
        move_steps = 2'($urandom_range(1, 3));
      end
      tick();
      move_req  = 1'b0;
      turn_done = 1'b0;
      check_state("wait", 1, 0);
    end
    if (use_done) turn_done = 1'b1;
    tick();
    turn_done = 1'b0;
    if (m_tile[a] == 10) begin
      m_go  = 1;
      m_win = a;
      check_state("win", 0, 0);
    end else begin
      check_state("switch", 1, 0);
      tick();
      m_act ^= 1;
      check_state("idle", 0, 0);
    end
  endtask

  initial begin
    int turns;
    int r;
    rst        = 1'b1;
    new_game   = 1'b0;
    move_req   = 1'b0;
    move_steps = 2'd0;
    turn_done  = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check_state("reset", 0, 0);

    play_turn(2, 1, 0, 0, 0);
    play_turn(1, 0, 0, 0, 0);

    move_req   = 1'b1;
    move_steps = 2'd0;
    tick();
    move_req = 1'b0;
    check_state("zero_steps", 0, 0);

    for (int g = 0; g < 6; g++) begin
      turns = 0;
      while (!m_go && turns < 60) begin
        r = int'($urandom_range(0, 15));
        play_turn(0, r[0] | r[1], r[2], r[3], $urandom_range(0, 11) == 0);
        turns++;
      end
      chk("game_ended", m_go, 1);
      move_req   = 1'b1;
      move_steps = 2'($urandom_range(1, 3));
      tick();
      tick();
      move_req = 1'b0;
      check_state("go_hold", 0, 0);
      if (g[0]) new_game = 1'b1;
      else      rst      = 1'b1;
      move_req   = 1'b1;
      move_steps = 2'd3;
      tick();
      new_game = 1'b0;
      rst      = 1'b0;
      move_req = 1'b0;
      model_reset();
      check_state("restart", 0, 0);
      tick();
      check_state("restart_idle", 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
